// File: rtl/io_seq_pkg.sv
// Shared definitions for the I/O output sequencer: FSM states, register
// select codes and the address-write ordering helper.
package io_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AL,
        ST_WR_AH,
        ST_WR_D,
        ST_STROBE,
        ST_WAIT_ACK,
        ST_DONE
    } state_e;

    localparam logic [1:0] REG_ADDR_L = 2'd0;
    localparam logic [1:0] REG_ADDR_H = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;

    // Writes always go L, H, D; the first one still needed is the next state.
    function automatic state_e first_write(input logic need_l, input logic need_h);
        if (need_l) return ST_WR_AL;
        if (need_h) return ST_WR_AH;
        return ST_WR_D;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips away from the winner
// whenever a grant is taken while enabled.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_id,
    output logic       gnt_vld
);

    logic ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_vld = |req;
        gnt_id  = 1'b0;
        ptr_d   = ptr_q;
        if (req == 2'b10)      gnt_id = 1'b1;
        else if (req == 2'b11) gnt_id = ptr_q;
        if (en && gnt_vld) ptr_d = ~gnt_id;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/io_out_sequencer.sv
// Shares the ADDR_L / ADDR_H / DATA output registers between the CPU and DMA
// requesters, strobes the peripheral and waits for ack or timeout.
module io_out_sequencer
    import io_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8,
    parameter bit          SKIP_ADDR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        reg_we,
    output logic [1:0]  reg_sel,
    output logic [7:0]  bus_out,
    output logic        io_strobe,
    input  logic        io_ack,
    output logic        done,
    output logic        done_id,
    output logic        done_err,
    output logic        busy
);

    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

    state_e          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            id_q, id_d;
    logic            err_q, err_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            shadow_vld_q, shadow_vld_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic        in_idle, gnt_id, gnt_vld;
    logic [15:0] gnt_addr;
    logic        need_l, need_h, need_h_held;

    assign in_idle = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .en      (in_idle),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign req0_ready = in_idle & gnt_vld & ~gnt_id & ~rst;
    assign req1_ready = in_idle & gnt_vld &  gnt_id & ~rst;

    assign gnt_addr    = gnt_id ? req1_addr : req0_addr;
    assign need_l      = !SKIP_ADDR || !shadow_vld_q || (gnt_addr[7:0]  != shadow_q[7:0]);
    assign need_h      = !SKIP_ADDR || !shadow_vld_q || (gnt_addr[15:8] != shadow_q[15:8]);
    // Shadow high byte is untouched by WR_AL, so re-deriving need_h there matches the IDLE decision.
    assign need_h_held = !SKIP_ADDR || !shadow_vld_q || (addr_q[15:8]   != shadow_q[15:8]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        id_d         = id_q;
        err_d        = err_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    addr_d  = gnt_addr;
                    data_d  = gnt_id ? req1_data : req0_data;
                    id_d    = gnt_id;
                    err_d   = 1'b0;
                    state_d = first_write(need_l, need_h);
                end
            end
            ST_WR_AL: begin
                shadow_d[7:0] = addr_q[7:0];
                state_d       = first_write(1'b0, need_h_held);
            end
            ST_WR_AH: begin
                shadow_d[15:8] = addr_q[15:8];
                state_d        = ST_WR_D;
            end
            ST_WR_D: begin
                shadow_vld_d = 1'b1;
                state_d      = ST_STROBE;
            end
            ST_STROBE: begin
                cnt_d   = '0;
                state_d = io_ack ? ST_DONE : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
                if (io_ack) begin
                    state_d = ST_DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: everything except the ready pair comes from the state register.
    always_comb begin
        reg_we    = 1'b0;
        reg_sel   = REG_ADDR_L;
        bus_out   = 8'h00;
        io_strobe = 1'b0;
        done      = 1'b0;
        done_id   = 1'b0;
        done_err  = 1'b0;
        busy      = !in_idle;
        case (state_q)
            ST_WR_AL:  begin reg_we = 1'b1; reg_sel = REG_ADDR_L; bus_out = addr_q[7:0];  end
            ST_WR_AH:  begin reg_we = 1'b1; reg_sel = REG_ADDR_H; bus_out = addr_q[15:8]; end
            ST_WR_D:   begin reg_we = 1'b1; reg_sel = REG_DATA;   bus_out = data_q;       end
            ST_STROBE: io_strobe = 1'b1;
            ST_DONE:   begin done = 1'b1; done_id = id_q; done_err = err_q; end
            default:   ;
        endcase
    end

    // NOTE: hold registers are reset too even though only shadow_vld matters, keeping outputs X-free after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            id_q         <= id_d;
            err_q        <= err_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_io_out_sequencer.sv
// Self-checking bench: a transaction-level model expands each grant into the
// expected per-cycle output trace; directed scenarios pin latencies and write order.
module tb_io_out_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_addr = '0, req1_addr = '0;
    logic [7:0]  req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, reg_we, io_strobe, done, done_id, done_err, busy;
    logic [1:0]  reg_sel;
    logic [7:0]  bus_out;
    logic        io_ack = 1'b0;

    io_out_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(3), .SKIP_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .reg_we(reg_we), .reg_sel(reg_sel), .bus_out(bus_out), .io_strobe(io_strobe), .io_ack(io_ack),
        .done(done), .done_id(done_id), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r0; logic r1; logic we; logic [1:0] sel; logic [7:0] bus;
        logic stb; logic dn; logic id; logic er; logic bsy;
    } out_t;
    typedef struct { out_t o; bit fix; bit ack; } slot_t;
    typedef struct { int c; bit id; } gnt_t;

    int   n_cmp = 0, n_err = 0, cyc = 0;
    bit   chk_en = 0;
    out_t exp_cur = '0, cmp_a, cmp_e;
    slot_t exp_q[$];

    bit          pend[2];
    logic [15:0] pa[2];
    logic [7:0]  pd[2];
    bit          mdl_ptr = 0, mdl_sv = 0;
    logic [15:0] mdl_sh = '0;
    int          mdl_grants = 0;
    int          forced_ack = -1;
    bit          ack_hi = 0;

    gnt_t       gnt_log[$];
    logic [9:0] wr_log[$];
    int         done_cyc = -1, n_done = 0;
    bit         done_id_l, done_err_l;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.r0 = req0_ready; o.r1 = req1_ready; o.we = reg_we; o.sel = reg_sel; o.bus = bus_out;
        o.stb = io_strobe; o.dn = done; o.id = done_id; o.er = done_err; o.bsy = busy;
        return o;
    endfunction

    // Single compare process: logs DUT activity and checks against the model every cycle.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            if (req0_ready) gnt_log.push_back('{cyc, 1'b0});
            if (req1_ready) gnt_log.push_back('{cyc, 1'b1});
            if (reg_we) wr_log.push_back({reg_sel, bus_out});
            if (done) begin done_cyc = cyc; done_id_l = done_id; done_err_l = done_err; n_done++; end
        end
        if (chk_en) begin
            cmp_a = dut_out();
            cmp_e = exp_cur;
            if (!cmp_e.we) begin cmp_a.sel = cmp_e.sel; cmp_a.bus = cmp_e.bus; end
            if (!cmp_e.dn) begin cmp_a.id = cmp_e.id; cmp_a.er = cmp_e.er; end
            check("outputs", 32'(cmp_a), 32'(cmp_e));
        end
    end

    function automatic bit noise();
        if (ack_hi) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [7:0] hi, lo;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        hi = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h34;
        lo = ($urandom_range(0, 1) != 0) ? 8'h56 : 8'h78;
        return {hi, lo};
    endfunction

    function automatic out_t busy_out();
        out_t o = '0;
        o.bsy = 1'b1;
        return o;
    endfunction

    task automatic push_wr(logic [1:0] sel, logic [7:0] b);
        slot_t s;
        s.o = busy_out(); s.o.we = 1'b1; s.o.sel = sel; s.o.bus = b; s.fix = 0; s.ack = 0;
        exp_q.push_back(s);
    endtask

    // Expand one accepted request into its full expected output trace.
    task automatic grant(bit g);
        logic [15:0] a;
        logic [7:0]  d;
        int          k, nw;
        slot_t       s;
        a = pa[g]; d = pd[g];
        pend[g] = 0; mdl_ptr = ~g; mdl_grants++;
        k = (forced_ack >= 0) ? forced_ack : int'($urandom_range(0, 6));
        if (!mdl_sv || a[7:0]  != mdl_sh[7:0])  push_wr(2'd0, a[7:0]);
        if (!mdl_sv || a[15:8] != mdl_sh[15:8]) push_wr(2'd1, a[15:8]);
        push_wr(2'd2, d);
        s.o = busy_out(); s.o.stb = 1'b1; s.fix = 1; s.ack = (k == 0);
        exp_q.push_back(s);
        if (k != 0) begin
            nw = (k <= TO) ? k : TO;
            for (int j = 1; j <= nw; j++) begin
                s.o = busy_out(); s.fix = 1; s.ack = (j == k);
                exp_q.push_back(s);
            end
        end
        s.o = busy_out(); s.o.dn = 1'b1; s.o.id = g; s.o.er = (k > TO); s.fix = 0; s.ack = 0;
        exp_q.push_back(s);
        mdl_sh = a; mdl_sv = 1;
    endtask

    task automatic drive_reqs();
        req0_valid = pend[0]; req1_valid = pend[1];
        req0_addr  = pend[0] ? pa[0] : 16'($urandom);
        req1_addr  = pend[1] ? pa[1] : 16'($urandom);
        req0_data  = pend[0] ? pd[0] : 8'($urandom);
        req1_data  = pend[1] ? pd[1] : 8'($urandom);
    endtask

    task automatic step();
        slot_t s;
        out_t  e;
        bit    g;
        @(negedge clk);
        drive_reqs();
        if (exp_q.size() == 0) begin
            e = '0;
            io_ack = noise();
            if (pend[0] || pend[1]) begin
                g = (pend[0] && pend[1]) ? mdl_ptr : pend[1];
                if (g) e.r1 = 1'b1; else e.r0 = 1'b1;
                grant(g);
            end
            exp_cur = e;
        end else begin
            s = exp_q.pop_front();
            io_ack  = s.fix ? s.ack : noise();
            exp_cur = s.o;
        end
    endtask

    task automatic spawn();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
                pend[i] = 1; pa[i] = rand_addr(); pd[i] = 8'($urandom);
            end
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete(); wr_log.delete(); n_done = 0; done_cyc = -1;
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst = 1'b1;
        exp_q.delete(); pend[0] = 0; pend[1] = 0; mdl_ptr = 0; mdl_sv = 0; mdl_sh = '0;
        req0_valid = 1'b0; req1_valid = 1'b0; io_ack = 1'b0;
        exp_cur = '0;
        #1;
        check("reset_outputs", 32'(dut_out()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
    endtask

    task automatic drain();
        int n = 0;
        do begin step(); n++; end
        while ((exp_q.size() != 0 || pend[0] || pend[1]) && n < 300);
        if (n >= 300) check("drain_timeout", n, 0);
        #3;
    endtask

    task automatic issue(bit id, logic [15:0] a, logic [7:0] d, int ackd);
        forced_ack = ackd;
        pend[id] = 1; pa[id] = a; pd[id] = d;
        clear_logs();
        drain();
        forced_ack = -1;
    endtask

    function automatic int lat();
        if (gnt_log.size() == 0 || n_done == 0) return -1;
        return done_cyc - gnt_log[0].c;
    endfunction

    task automatic check_wr(string name, int idx, logic [1:0] sel, logic [7:0] b);
        check(name, (idx < wr_log.size()) ? 32'(wr_log[idx]) : 32'h3ff, 32'({sel, b}));
    endtask

    initial begin
        int n, base;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        #3;
        do_reset();

        // Full path, ack on the first WAIT_ACK cycle.
        issue(1'b0, 16'h1234, 8'hAB, 1);
        check("t1_latency", lat(), 6);
        check("t1_nwrites", wr_log.size(), 3);
        check_wr("t1_wr0", 0, 2'd0, 8'h34);
        check_wr("t1_wr1", 1, 2'd1, 8'h12);
        check_wr("t1_wr2", 2, 2'd2, 8'hAB);
        check("t1_id_err", {done_id_l, done_err_l}, 2'b00);

        // Same address: only DATA written.
        issue(1'b0, 16'h1234, 8'hCD, 1);
        check("t2a_latency", lat(), 4);
        check("t2a_nwrites", wr_log.size(), 1);
        check_wr("t2a_wr0", 0, 2'd2, 8'hCD);
        issue(1'b0, 16'h1299, 8'h01, 1);
        check("t2b_latency", lat(), 5);
        check("t2b_nwrites", wr_log.size(), 2);
        check_wr("t2b_wr0", 0, 2'd0, 8'h99);
        check_wr("t2b_wr1", 1, 2'd2, 8'h01);

        // Timeout with ack held low: 4 WAIT_ACK cycles then DONE with err.
        issue(1'b1, 16'h1299, 8'h77, 99);
        check("t4_latency", lat(), 7);
        check("t4_id_err", {done_id_l, done_err_l}, 2'b11);

        // Reset in the middle of WR_AH, then the same address again.
        pend[0] = 1; pa[0] = 16'hBEEF; pd[0] = 8'h55; forced_ack = 1;
        n = 0;
        do begin step(); n++; end while (!(exp_cur.we && exp_cur.sel == 2'd1) && n < 20);
        forced_ack = -1;
        check("t5_in_wr_ah", {reg_we, reg_sel, bus_out}, {1'b1, 2'd1, 8'hBE});
        do_reset();
        issue(1'b0, 16'hBEEF, 8'h66, 1);
        check("t5_latency", lat(), 6);
        check("t5_nwrites", wr_log.size(), 3);
        check_wr("t5_wr0", 0, 2'd0, 8'hEF);
        check_wr("t5_wr1", 1, 2'd1, 8'hBE);

        // Both requesters continuously valid: grants alternate.
        do_reset();
        clear_logs();
        base = mdl_grants;
        for (int i = 0; i < 2; i++) begin pend[i] = 1; pa[i] = rand_addr(); pd[i] = 8'($urandom); end
        n = 0;
        while ((mdl_grants - base < 4 || exp_q.size() != 0) && n < 300) begin
            step(); n++;
            for (int i = 0; i < 2; i++)
                if (!pend[i] && (mdl_grants - base + int'(pend[0]) + int'(pend[1])) < 4) begin
                    pend[i] = 1; pa[i] = rand_addr(); pd[i] = 8'($urandom);
                end
        end
        #3;
        check("t3_ngrants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t3_grant_id", (i < gnt_log.size()) ? 32'(gnt_log[i].id) : 32'h2, 32'(i % 2));

        // Ack during STROBE, then ack pulses while idle.
        do_reset();
        issue(1'b0, 16'h4242, 8'h10, 0);
        check("t6_latency", lat(), 5);
        ack_hi = 1;
        repeat (6) step();
        ack_hi = 0;
        #3;
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_no_done", n_done, 1);

        // Randomised traffic against the model.
        clear_logs();
        base = mdl_grants;
        for (int i = 0; i < 4000; i++) begin spawn(); step(); end
        drain();
        check("rand_done_count", n_done, mdl_grants - base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
